// File: rtl/cu_sequencer.sv
// Hard-wired control sequencer for the ARM-subset multicycle datapath.
// Fetches over a moc-handshaked memory port, decodes ir, then steps the
// datapath through data-processing, load/store-word and branch sequences.
// Optional feature macro: CU_BRANCH_LINK_EN (adds the BL state that writes R14).
module cu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        cond_true,
    input  logic        moc,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [2:0]  MC,
    output logic        MD,
    output logic [4:0]  op,
    output logic        MG,
    output logic [1:0]  MJ,
    output logic        rf_ld,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        flags_ld,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [3:0]  state
);

    localparam logic [4:0] OpAdd   = 5'b00100;
    localparam logic [4:0] OpSub   = 5'b00010;
    localparam logic [4:0] OpPassB = 5'b01101;
    localparam logic [4:0] OpPassA = 5'b10000;

    typedef enum logic [3:0] {
        StRst      = 4'd0,
        StFetch0   = 4'd1,
        StFetch1   = 4'd2,
        StFetch2   = 4'd3,
        StDecode   = 4'd4,
        StDp       = 4'd5,
        StLsAddr   = 4'd6,
        StLsLd0    = 4'd7,
        StLsLd1    = 4'd8,
        StLsSt0    = 4'd9,
        StLsSt1    = 4'd10,
        StBr       = 4'd11,
        StBl       = 4'd12,
        StUnused13 = 4'd13,
        StUnused14 = 4'd14,
        StUnused15 = 4'd15
    } state_e;

    state_e state_q, state_d;

    // Condition field, shift/register fields and low opcode bits are consumed by the datapath.
    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0]};

    assign state = state_q;

    // State register with synchronous reset that overrides any pending memory wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; every control defaults to 0.
    always_comb begin
        state_d  = StRst;
        MA       = 2'd0;
        MB       = 2'd0;
        MC       = 3'd0;
        MD       = 1'b0;
        op       = 5'd0;
        MG       = 1'b0;
        MJ       = 2'd0;
        rf_ld    = 1'b0;
        ir_ld    = 1'b0;
        mar_ld   = 1'b0;
        mdr_ld   = 1'b0;
        flags_ld = 1'b0;
        mem_mov  = 1'b0;
        mem_rw   = 1'b0;

        case (state_q)
            StRst: begin
                state_d = StFetch0;
            end
            StFetch0: begin
                MA      = 2'd2;
                MD      = 1'b1;
                op      = OpPassA;
                mar_ld  = 1'b1;
                state_d = StFetch1;
            end
            StFetch1: begin
                // Memory read starts while PC+4 is written back.
                mem_mov = 1'b1;
                mem_rw  = 1'b1;
                MA      = 2'd2;
                MB      = 2'd3;
                MD      = 1'b1;
                op      = OpAdd;
                MC      = 3'd3;
                rf_ld   = 1'b1;
                state_d = StFetch2;
            end
            StFetch2: begin
                mem_mov = 1'b1;
                mem_rw  = 1'b1;
                ir_ld   = moc;
                state_d = moc ? StDecode : StFetch2;
            end
            StDecode: begin
                if (!cond_true) begin
                    state_d = StFetch0;
                end else begin
                    case (ir[27:25])
                        3'b000, 3'b001: state_d = StDp;
                        3'b010:         state_d = StLsAddr;
`ifdef CU_BRANCH_LINK_EN
                        3'b101:         state_d = ir[24] ? StBl : StBr;
`else
                        3'b101:         state_d = StBr;
`endif
                        default:        state_d = StFetch0;
                    endcase
                end
            end
            StDp: begin
                MB       = 2'd1;
                // Test/compare opcodes (ir[24:23] == 2'b10) only update flags.
                rf_ld    = (ir[24:23] != 2'b10);
                flags_ld = ir[20];
                state_d  = StFetch0;
            end
            StLsAddr: begin
                MB      = 2'd1;
                MD      = 1'b1;
                op      = ir[23] ? OpAdd : OpSub;
                mar_ld  = 1'b1;
                state_d = ir[20] ? StLsLd0 : StLsSt0;
            end
            StLsLd0: begin
                mem_mov = 1'b1;
                mem_rw  = 1'b1;
                mdr_ld  = moc;
                state_d = moc ? StLsLd1 : StLsLd0;
            end
            StLsLd1: begin
                MB      = 2'd2;
                MD      = 1'b1;
                op      = OpPassB;
                rf_ld   = 1'b1;
                state_d = StFetch0;
            end
            StLsSt0: begin
                MJ      = 2'd2;
                MG      = 1'b1;
                mdr_ld  = 1'b1;
                state_d = StLsSt1;
            end
            StLsSt1: begin
                mem_mov = 1'b1;
                state_d = moc ? StFetch0 : StLsSt1;
            end
            StBr: begin
                // PC was already incremented during fetch.
                MA      = 2'd2;
                MB      = 2'd1;
                MD      = 1'b1;
                op      = OpAdd;
                MC      = 3'd3;
                rf_ld   = 1'b1;
                state_d = StFetch0;
            end
`ifdef CU_BRANCH_LINK_EN
            StBl: begin
                MA      = 2'd2;
                MD      = 1'b1;
                op      = OpPassA;
                MC      = 3'd2;
                rf_ld   = 1'b1;
                state_d = StBr;
            end
`endif
            default: begin
                state_d = StRst;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer.
// Each step compares {state, all control outputs} against a hand-built vector.
module tb_cu_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        cond_true;
    logic        moc;
    logic [1:0]  MA;
    logic [1:0]  MB;
    logic [2:0]  MC;
    logic        MD;
    logic [4:0]  op;
    logic        MG;
    logic [1:0]  MJ;
    logic        rf_ld;
    logic        ir_ld;
    logic        mar_ld;
    logic        mdr_ld;
    logic        flags_ld;
    logic        mem_mov;
    logic        mem_rw;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    cu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .ir       (ir),
        .cond_true(cond_true),
        .moc      (moc),
        .MA       (MA),
        .MB       (MB),
        .MC       (MC),
        .MD       (MD),
        .op       (op),
        .MG       (MG),
        .MJ       (MJ),
        .rf_ld    (rf_ld),
        .ir_ld    (ir_ld),
        .mar_ld   (mar_ld),
        .mdr_ld   (mdr_ld),
        .flags_ld (flags_ld),
        .mem_mov  (mem_mov),
        .mem_rw   (mem_rw),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ADD = 5'b00100;
    localparam int SUB = 5'b00010;
    localparam int PB  = 5'b01101;
    localparam int PA  = 5'b10000;

    // {state, MA, MB, MC, MD, op, MG, MJ, rf, ir, mar, mdr, flags, mem_mov, mem_rw}
    logic [26:0] obs;
    assign obs = {state, MA, MB, MC, MD, op, MG, MJ,
                  rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_mov, mem_rw};

    function automatic logic [26:0] ev(input int st, input int ma, input int mb, input int mc,
                                       input int md, input int opv, input int mg, input int mj,
                                       input int rf, input int irl, input int mar, input int mdr,
                                       input int fl, input int mm, input int rw);
        return {st[3:0], ma[1:0], mb[1:0], mc[2:0], md[0], opv[4:0], mg[0], mj[1:0],
                rf[0], irl[0], mar[0], mdr[0], fl[0], mm[0], rw[0]};
    endfunction

    logic [26:0] e_f0, e_f1, e_f2w, e_f2d, e_dec, e_br;

    // Leaves the DUT having just entered FETCH0 at the current edge.
    task automatic go_fetch0();
        moc   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        ir        = 32'hE0812003;
        cond_true = 1'b1;
        moc       = 1'b1;
        reset     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (obs !== 27'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h, expected %h", i, obs, 27'd0);
            end
        end
        reset = 1'b0;
        moc   = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (obs !== e_f0) begin
            errors++;
            $display("FAIL reset_release_fetch0: got %h, expected %h", obs, e_f0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== e_f1) begin
            errors++;
            $display("FAIL reset_release_fetch1: got %h, expected %h", obs, e_f1);
        end
    endtask

    // ADD writes Rd without flags; CMP writes flags only. moc held high to show it is ignored.
    task automatic test_dp();
        logic [26:0] e[6];
        logic [31:0] irs[2];
        irs[0] = 32'hE0812003;
        irs[1] = 32'hE1530004;
        for (int k = 0; k < 2; k++) begin
            ir = irs[k];
            cond_true = 1'b1;
            e[0] = e_f0; e[1] = e_f1; e[2] = e_f2d; e[3] = e_dec; e[5] = e_f0;
            e[4] = (k == 0) ? ev(5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)
                            : ev(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            go_fetch0();
            for (int i = 0; i < 6; i++) begin
                if (i > 0) @(posedge clk);
                #1 moc = 1'b1;
                #1;
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL dp%0d step %0d: got %h, expected %h", k, i, obs, e[i]);
                end
            end
        end
    endtask

    // LDR with three moc=0 cycles in the load wait.
    task automatic test_load();
        logic [26:0] e[11];
        logic        m[11];
        logic [26:0] w;
        ir = 32'hE5912004;
        cond_true = 1'b1;
        w = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        e[0] = e_f0;  e[1] = e_f1;  e[2] = e_f2d; e[3] = e_dec;
        e[4] = ev(6, 0, 1, 0, 1, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e[5] = w;     e[6] = w;     e[7] = w;
        e[8] = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        e[9] = ev(8, 0, 2, 0, 1, PB, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        e[10] = e_f0;
        for (int i = 0; i < 11; i++) m[i] = (i == 2) || (i == 8);
        go_fetch0();
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(posedge clk);
            #1 moc = m[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL load step %0d: got %h, expected %h", i, obs, e[i]);
            end
        end
    endtask

    // STR with one moc=0 cycle in the write wait.
    task automatic test_store();
        logic [26:0] e[9];
        logic        m[9];
        ir = 32'hE5812004;
        cond_true = 1'b1;
        e[0] = e_f0;  e[1] = e_f1;  e[2] = e_f2d; e[3] = e_dec;
        e[4] = ev(6, 0, 1, 0, 1, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e[5] = ev(9, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0);
        e[6] = ev(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e[7] = e[6];
        e[8] = e_f0;
        for (int i = 0; i < 9; i++) m[i] = (i == 2) || (i == 7);
        go_fetch0();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(posedge clk);
            #1 moc = m[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL store step %0d: got %h, expected %h", i, obs, e[i]);
            end
        end
    endtask

    // Down-offset load address uses SUB.
    task automatic test_sub_offset();
        logic [26:0] e[6];
        ir = 32'hE5112004;
        cond_true = 1'b1;
        e[0] = e_f0; e[1] = e_f1; e[2] = e_f2d; e[3] = e_dec;
        e[4] = ev(6, 0, 1, 0, 1, SUB, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e[5] = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        go_fetch0();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(posedge clk);
            #1 moc = (i == 2);
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sub_offset step %0d: got %h, expected %h", i, obs, e[i]);
            end
        end
    endtask

    // BL (k=0) and plain B (k=1).
    task automatic test_branch();
        logic [26:0] e[7];
        int          n;
        for (int k = 0; k < 2; k++) begin
            ir = (k == 0) ? 32'hEB000010 : 32'hEA000010;
            cond_true = 1'b1;
            e[0] = e_f0; e[1] = e_f1; e[2] = e_f2d; e[3] = e_dec;
`ifdef CU_BRANCH_LINK_EN
            if (k == 0) begin
                e[4] = ev(12, 2, 0, 2, 1, PA, 0, 0, 1, 0, 0, 0, 0, 0, 0);
                e[5] = e_br;
                e[6] = e_f0;
                n = 7;
            end else begin
                e[4] = e_br;
                e[5] = e_f0;
                n = 6;
            end
`else
            e[4] = e_br;
            e[5] = e_f0;
            n = 6;
`endif
            go_fetch0();
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(posedge clk);
                #1 moc = (i == 2);
                #1;
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL branch%0d step %0d: got %h, expected %h", k, i, obs, e[i]);
                end
            end
        end
    endtask

    // Condition fail on ADD, then two undefined ir[27:25] groups: all return to FETCH0.
    task automatic test_cond_fail_nop();
        logic [26:0] e[5];
        logic [31:0] irs[3];
        logic        cts[3];
        irs[0] = 32'hE0812003; cts[0] = 1'b0;
        irs[1] = 32'hE6000000; cts[1] = 1'b1;
        irs[2] = 32'hEC000000; cts[2] = 1'b1;
        e[0] = e_f0; e[1] = e_f1; e[2] = e_f2d; e[3] = e_dec; e[4] = e_f0;
        for (int k = 0; k < 3; k++) begin
            ir = irs[k];
            cond_true = cts[k];
            go_fetch0();
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(posedge clk);
                #1 moc = (i == 2);
                #1;
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL skip%0d step %0d: got %h, expected %h", k, i, obs, e[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        ir = 32'hE0812003;
        cond_true = 1'b1;
        go_fetch0();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (obs !== e_f2w) begin
            errors++;
            $display("FAIL wait_fetch2: got %h, expected %h", obs, e_f2w);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (obs !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: got %h, expected %h", obs, 27'd0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        ir        = 32'd0;
        cond_true = 1'b0;
        moc       = 1'b0;
        e_f0  = ev(1, 2, 0, 0, 1, PA, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_f1  = ev(2, 2, 3, 3, 1, ADD, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        e_f2w = ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        e_f2d = ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        e_dec = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_br  = ev(11, 2, 1, 3, 1, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        test_reset();
        test_dp();
        test_load();
        test_store();
        test_sub_offset();
        test_branch();
        test_cond_fail_nop();
        test_reset_mid_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
